// File: rtl/shift_rx_deser.sv
// Serial-to-parallel receiver: start-strobed frames of WIDTH bits, selectable bit order, abort on restart.
// Optional even-parity bit after the data word when PARITY_EN is defined.
module shift_rx_deser #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sin,
    input  logic             sin_vld,
    input  logic             lsb_first,
    output logic [WIDTH-1:0] dout,
    output logic             dout_vld,
    output logic             busy,
    output logic             abort,
    output logic             par_err
);

    localparam int CW = $clog2(WIDTH + 1);

`ifdef PARITY_EN
    typedef enum logic [1:0] {IDLE, RECV, PAR} state_t;
`else
    typedef enum logic [1:0] {IDLE, RECV} state_t;
`endif

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sh;
    logic [WIDTH-1:0] sh_nxt;
    logic             lsb_r;
    logic             restart;
    logic             accept;
    logic             word_done;

    function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] s,
                                                  input logic b,
                                                  input logic lsb);
        return lsb ? {b, s[WIDTH-1:1]} : {s[WIDTH-2:0], b};
    endfunction

    assign busy   = (state != IDLE);
    assign sh_nxt = shift_in(sh, sin, lsb_r);

    always_comb begin
        state_nxt = state;
        restart   = 1'b0;
        accept    = 1'b0;
        word_done = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RECV;
                    restart   = 1'b1;
                end
            end
            RECV: begin
                if (start) begin
                    restart = 1'b1;
                end else if (sin_vld) begin
                    accept = 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
`ifdef PARITY_EN
                        state_nxt = PAR;
`else
                        word_done = 1'b1;
                        state_nxt = IDLE;
`endif
                    end
                end
            end
`ifdef PARITY_EN
            PAR: begin
                if (start) begin
                    state_nxt = RECV;
                    restart   = 1'b1;
                end else if (sin_vld) begin
                    word_done = 1'b1;
                    state_nxt = IDLE;
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            sh       <= '0;
            lsb_r    <= 1'b0;
            dout     <= '0;
            dout_vld <= 1'b0;
            abort    <= 1'b0;
        end else begin
            state    <= state_nxt;
            dout_vld <= word_done;
            // Only a restart that interrupts a frame counts as an abort.
            abort    <= restart && busy;
            if (restart) begin
                cnt   <= '0;
                sh    <= '0;
                lsb_r <= lsb_first;
            end else if (accept) begin
                cnt <= cnt + 1'b1;
                sh  <= sh_nxt;
            end
            if (word_done) begin
`ifdef PARITY_EN
                dout <= sh;
`else
                dout <= sh_nxt;
`endif
            end
        end
    end

`ifdef PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_err <= 1'b0;
        end else if (word_done) begin
            par_err <= (^sh) ^ sin;
        end
    end
`else
    assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_shift_rx_deser.sv
// Self-checking bench for shift_rx_deser (WIDTH=4) with a word-level reference model.
module tb_shift_rx_deser;

    localparam int W = 4;
`ifdef PARITY_EN
    localparam bit PAR_ON = 1'b1;
`else
    localparam bit PAR_ON = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst, start, sin, sin_vld, lsb_first;
    logic [W-1:0] dout;
    logic         dout_vld, busy, abort, par_err;

    int           n_cmp = 0;
    int           n_err = 0;
    logic [W-1:0] exp_dout;
    logic         exp_par;

    shift_rx_deser #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .sin(sin), .sin_vld(sin_vld),
        .lsb_first(lsb_first), .dout(dout), .dout_vld(dout_vld), .busy(busy),
        .abort(abort), .par_err(par_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Start strobe with a noisy sin_vld (must be ignored); lsb_first is toggled afterwards
    // so the frame only works if the order was latched at start.
    task automatic do_start(input logic lsb);
        start     = 1'b1;
        lsb_first = lsb;
        sin_vld   = 1'b1;
        sin       = 1'($urandom);
        step();
        start     = 1'b0;
        sin_vld   = 1'b0;
        lsb_first = ~lsb;
    endtask

    task automatic drive_bit(input logic b, input int gap, inout logic busy_ok, inout logic vld_seen);
        for (int g = 0; g < gap; g++) begin
            sin_vld = 1'b0;
            sin     = 1'($urandom);
            step();
            if (!busy) busy_ok = 1'b0;
            if (dout_vld) vld_seen = 1'b1;
        end
        sin_vld = 1'b1;
        sin     = b;
        step();
        sin_vld = 1'b0;
    endtask

    // Sends word w (plus parity bit when enabled); returns just after the final accepted edge.
    task automatic drive_word(input logic [W-1:0] w, input logic lsb, input int gap, input bit rnd_gap,
                              input logic flip, output logic busy_ok, output logic early_vld);
        int   nbits;
        logic b;
        busy_ok   = 1'b1;
        early_vld = 1'b0;
        nbits     = PAR_ON ? W + 1 : W;
        for (int i = 0; i < nbits; i++) begin
            if (i == W) b = (^w) ^ flip;
            else        b = lsb ? w[i] : w[W-1-i];
            drive_bit(b, rnd_gap ? int'($urandom_range(0, gap)) : gap, busy_ok, early_vld);
            if (i < nbits - 1) begin
                if (!busy) busy_ok = 1'b0;
                if (dout_vld) early_vld = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; sin = 1'b0; sin_vld = 1'b0; lsb_first = 1'b0;
        #2;
        n_cmp++;
        if ({dout, dout_vld, busy, abort, par_err} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got %b want all zero", {dout, dout_vld, busy, abort, par_err});
        end
        step();
        rst = 1'b0;
        sin_vld = 1'b1; sin = 1'b1;
        step(); step();
        sin_vld = 1'b0;
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL idle_no_start: busy got %b want 0", busy); end
        exp_dout = '0;
        exp_par  = 1'b0;
    endtask

    task automatic test_msb();
        logic bok, early;
        do_start(1'b0);
        drive_word(4'b1001, 1'b0, 0, 1'b0, 1'b0, bok, early);
        exp_dout = 4'b1001;
        n_cmp++;
        if (dout_vld !== 1'b1 || dout !== exp_dout) begin
            n_err++; $display("FAIL msb_word: got vld=%b dout=%b want vld=1 dout=%b", dout_vld, dout, exp_dout);
        end
        n_cmp++;
        if (busy !== 1'b0 || bok !== 1'b1 || early !== 1'b0) begin
            n_err++; $display("FAIL msb_busy: got busy=%b held=%b early=%b want 0 1 0", busy, bok, early);
        end
        step();
        n_cmp++;
        if (dout_vld !== 1'b0 || dout !== exp_dout) begin
            n_err++; $display("FAIL msb_pulse: got vld=%b dout=%b want vld=0 dout=%b", dout_vld, dout, exp_dout);
        end
    endtask

    task automatic test_lsb_gaps();
        logic bok, early;
        do_start(1'b1);
        drive_word(4'b0011, 1'b1, 2, 1'b0, 1'b0, bok, early);
        exp_dout = 4'b0011;
        n_cmp++;
        if (dout_vld !== 1'b1 || dout !== exp_dout) begin
            n_err++; $display("FAIL lsb_word: got vld=%b dout=%b want vld=1 dout=%b", dout_vld, dout, exp_dout);
        end
        n_cmp++;
        if (bok !== 1'b1 || early !== 1'b0) begin
            n_err++; $display("FAIL lsb_busy_held: got held=%b early=%b want 1 0", bok, early);
        end
    endtask

    task automatic test_abort();
        logic bok, early;
        do_start(1'b0);
        bok = 1'b1; early = 1'b0;
        drive_bit(1'b0, 0, bok, early);
        drive_bit(1'b1, 1, bok, early);
        start = 1'b1; lsb_first = 1'b0; sin_vld = 1'b1; sin = 1'b1;
        step();
        start = 1'b0; sin_vld = 1'b0;
        n_cmp++;
        if (abort !== 1'b1 || dout !== exp_dout || dout_vld !== 1'b0 || busy !== 1'b1) begin
            n_err++; $display("FAIL abort_pulse: got abort=%b dout=%b vld=%b busy=%b want 1 %b 0 1",
                              abort, dout, dout_vld, busy, exp_dout);
        end
        step();
        n_cmp++;
        if (abort !== 1'b0) begin n_err++; $display("FAIL abort_one_cycle: got %b want 0", abort); end
        drive_word(4'b1011, 1'b0, 0, 1'b0, 1'b0, bok, early);
        exp_dout = 4'b1011;
        n_cmp++;
        if (dout_vld !== 1'b1 || dout !== exp_dout) begin
            n_err++; $display("FAIL abort_next_word: got vld=%b dout=%b want vld=1 dout=%b", dout_vld, dout, exp_dout);
        end
        // Restart landing on the edge that would accept the last data bit.
        do_start(1'b1);
        for (int i = 0; i < W - 1; i++) drive_bit(1'($urandom), 0, bok, early);
        start = 1'b1; lsb_first = 1'b0; sin_vld = 1'b1; sin = 1'b0;
        step();
        start = 1'b0; sin_vld = 1'b0;
        n_cmp++;
        if (abort !== 1'b1 || dout_vld !== 1'b0 || dout !== exp_dout) begin
            n_err++; $display("FAIL abort_last_edge: got abort=%b vld=%b dout=%b want 1 0 %b", abort, dout_vld, dout, exp_dout);
        end
        drive_word(4'b0101, 1'b0, 1, 1'b0, 1'b0, bok, early);
        exp_dout = 4'b0101;
        n_cmp++;
        if (dout_vld !== 1'b1 || dout !== exp_dout) begin
            n_err++; $display("FAIL abort_last_recover: got vld=%b dout=%b want vld=1 dout=%b", dout_vld, dout, exp_dout);
        end
        step();
    endtask

    task automatic test_mid_reset();
        logic bok, early;
        logic seen;
        do_start(1'b0);
        bok = 1'b1; early = 1'b0;
        drive_bit(1'b1, 0, bok, early);
        drive_bit(1'b1, 0, bok, early);
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({dout, dout_vld, busy, abort, par_err} !== '0) begin
            n_err++; $display("FAIL async_reset: got %b want all zero", {dout, dout_vld, busy, abort, par_err});
        end
        step();
        rst = 1'b0;
        seen = 1'b0;
        sin_vld = 1'b1;
        for (int i = 0; i < W + 2; i++) begin
            sin = 1'($urandom);
            step();
            if (busy || dout_vld || abort) seen = 1'b1;
        end
        sin_vld = 1'b0;
        n_cmp++;
        if (seen !== 1'b0) begin n_err++; $display("FAIL reset_no_resume: got activity=%b want 0", seen); end
        exp_dout = '0;
        exp_par  = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic bok, early;
        do_start(1'b0);
        drive_word(4'b1100, 1'b0, 0, 1'b0, 1'b0, bok, early);
        exp_dout = 4'b1100;
        n_cmp++;
        if (dout_vld !== 1'b1 || dout !== exp_dout) begin
            n_err++; $display("FAIL b2b_first: got vld=%b dout=%b want vld=1 dout=%b", dout_vld, dout, exp_dout);
        end
        do_start(1'b0);
        n_cmp++;
        if (busy !== 1'b1 || abort !== 1'b0 || dout_vld !== 1'b0) begin
            n_err++; $display("FAIL b2b_start: got busy=%b abort=%b vld=%b want 1 0 0", busy, abort, dout_vld);
        end
        drive_word(4'b0110, 1'b0, 0, 1'b0, 1'b0, bok, early);
        exp_dout = 4'b0110;
        n_cmp++;
        if (dout_vld !== 1'b1 || dout !== exp_dout || early !== 1'b0) begin
            n_err++; $display("FAIL b2b_second: got vld=%b dout=%b early=%b want 1 %b 0", dout_vld, dout, early, exp_dout);
        end
        step();
    endtask

    task automatic test_parity();
        logic bok, early;
        for (int k = 0; k < 2; k++) begin
            do_start(1'b0);
            drive_word(4'b1011, 1'b0, 1, 1'b0, (k == 0) ? 1'b1 : 1'b0, bok, early);
            exp_dout = 4'b1011;
            exp_par  = PAR_ON ? ((k == 0) ? 1'b1 : 1'b0) : 1'b0;
            n_cmp++;
            if (dout_vld !== 1'b1 || dout !== exp_dout || early !== 1'b0) begin
                n_err++; $display("FAIL par_word_%0d: got vld=%b dout=%b early=%b want 1 %b 0", k, dout_vld, dout, early, exp_dout);
            end
            step(); step();
            n_cmp++;
            if (par_err !== exp_par) begin
                n_err++; $display("FAIL par_err_%0d: got %b want %b", k, par_err, exp_par);
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] w;
        logic         lsb, flip, bok, early;
        int           k;
        for (int n = 0; n < 40; n++) begin
            w    = W'($urandom);
            lsb  = 1'($urandom);
            flip = 1'($urandom);
            do_start(lsb);
            if ($urandom_range(0, 3) == 0) begin
                k = $urandom_range(0, W - 1);
                bok = 1'b1; early = 1'b0;
                for (int i = 0; i < k; i++) drive_bit(1'($urandom), $urandom_range(0, 2), bok, early);
                start = 1'b1; lsb_first = lsb;
                step();
                start = 1'b0; lsb_first = ~lsb;
                n_cmp++;
                if (abort !== 1'b1 || dout !== exp_dout) begin
                    n_err++; $display("FAIL rnd_abort_%0d: got abort=%b dout=%b want 1 %b", n, abort, dout, exp_dout);
                end
            end
            drive_word(w, lsb, 3, 1'b1, flip, bok, early);
            exp_dout = w;
            exp_par  = PAR_ON ? flip : 1'b0;
            n_cmp++;
            if (dout_vld !== 1'b1 || dout !== exp_dout || par_err !== exp_par || busy !== 1'b0) begin
                n_err++; $display("FAIL rnd_word_%0d: got vld=%b dout=%b par=%b busy=%b want 1 %b %b 0",
                                  n, dout_vld, dout, par_err, busy, exp_dout, exp_par);
            end
            n_cmp++;
            if (bok !== 1'b1 || early !== 1'b0) begin
                n_err++; $display("FAIL rnd_frame_%0d: got held=%b early=%b want 1 0", n, bok, early);
            end
            k = $urandom_range(1, 3);
            for (int i = 0; i < k; i++) step();
            n_cmp++;
            if (dout_vld !== 1'b0 || dout !== exp_dout || par_err !== exp_par) begin
                n_err++; $display("FAIL rnd_hold_%0d: got vld=%b dout=%b par=%b want 0 %b %b",
                                  n, dout_vld, dout, par_err, exp_dout, exp_par);
            end
        end
    endtask

    initial begin
        test_reset();
        test_msb();
        test_lsb_gaps();
        test_abort();
        test_mid_reset();
        test_back_to_back();
        test_parity();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
